// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU run-control
// state machine (master) and the ALU execution unit (slave).
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output load, opcode, a, b,
    input  busy, done, result, overflow
  );

  modport slave (
    input  load, opcode, a, b,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle ADD/SUB, WIDTH-step
// shift-add MUL and restoring DIV.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_exec_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;
  logic   start;
  logic   fin;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] mc_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   res_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   trial;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_ovf;
  logic               ld_multi;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and control strobes
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fin      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          state_nx = EXEC;
          start    = 1'b1;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_nx = DONE;
          fin      = 1'b1;
        end
      end
      DONE: begin
        if (bus.load) begin
          state_nx = EXEC;
          start    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // One iteration step for MUL and DIV, plus ADD/SUB
  always_comb begin
    mul_nx = acc_q + (b_q[0] ? mc_q : '0);
    rem_sh = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, b_q};
    qbit   = ~trial[WIDTH+1];
    rem_nx = qbit ? trial[WIDTH-1:0]
                  : rem_sh[WIDTH-1:0];
    quo_nx = {a_q[WIDTH-2:0], qbit};
    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
  end

  // Final result/flag selected by the captured opcode
  always_comb begin
    fin_res = '0;
    fin_ovf = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD): begin
        fin_res = sum[WIDTH-1:0];
        fin_ovf = sum[WIDTH];
      end
      (op_q == OP_SUB): begin
        fin_res = diff[WIDTH-1:0];
        fin_ovf = diff[WIDTH];
      end
      (op_q == OP_MUL): begin
        fin_res = mul_nx[WIDTH-1:0];
        fin_ovf = |mul_nx[2*WIDTH-1:WIDTH];
      end
      (op_q == OP_DIV): begin
        if (b_q == '0) begin
          fin_res = '1;
          fin_ovf = 1'b1;
        end else begin
          fin_res = quo_nx;
          fin_ovf = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Divide by zero skips iteration entirely
  always_comb begin
    ld_multi = 1'b0;
    if (bus.opcode == OP_MUL)
      ld_multi = 1'b1;
    else if (bus.opcode == OP_DIV)
      ld_multi = (bus.b != '0);
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mc_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (start) begin
      op_q  <= bus.opcode;
      a_q   <= bus.a;
      b_q   <= bus.b;
      mc_q  <= {{WIDTH{1'b0}}, bus.a};
      acc_q <= '0;
      cnt_q <= ld_multi ? CW'(WIDTH - 1) : '0;
    end else if (state == EXEC) begin
      if (fin) begin
        res_q <= fin_res;
        ovf_q <= fin_ovf;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (op_q == OP_MUL) begin
        acc_q <= mul_nx;
        mc_q  <= mc_q << 1;
        b_q   <= b_q >> 1;
      end else if (op_q == OP_DIV && b_q != '0) begin
        acc_q <= {{WIDTH{1'b0}}, rem_nx};
        a_q   <= quo_nx;
      end
    end
  end

  assign bus.busy     = (state == EXEC);
  assign bus.done     = (state == DONE);
  assign bus.result   = res_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised scoreboard bench for alu_exec_unit:
// arithmetic reference model, latency and hold checks.
module tb_alu_exec_unit;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int res;
    int ovf;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   held_res = 0;
  int   held_ovf = 0;
  exp_t sb[$];

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input int act,
                              input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               nm, act, exp);
    end
  endfunction

  function automatic void model(input logic [1:0] op,
                                input int av, input int bv,
                                output int r, output int o,
                                output int lat);
    int t;
    r = 0; o = 0; lat = 1;
    case (op)
      2'd0: begin
        t = av + bv;
        r = t & MASK; o = (t > MASK) ? 1 : 0;
      end
      2'd1: begin
        t = av - bv;
        r = t & MASK; o = (av < bv) ? 1 : 0;
      end
      2'd2: begin
        t = av * bv;
        r = t & MASK; o = ((t >> W) != 0) ? 1 : 0;
        lat = W;
      end
      default: begin
        if (bv == 0) begin
          r = MASK; o = 1;
        end else begin
          r = av / bv; o = 0; lat = W;
        end
      end
    endcase
  endfunction

  // Called #1 after an edge with the unit not busy.
  task automatic issue(input logic [1:0] op,
                       input int av, input int bv,
                       input bit track);
    exp_t e;
    int r, o, l;
    bus.load   = 1'b1;
    bus.opcode = op;
    bus.a      = av[W-1:0];
    bus.b      = bv[W-1:0];
    if (track) begin
      model(op, av, bv, r, o, l);
      e.res = r; e.ovf = o; e.cyc = cyc + 1 + l;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  task automatic wait_free();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("busy_timeout", 1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy && bus.done)
        chk("busy_and_done", 1, 0);
      if (bus.busy) begin
        chk("result_hold", int'(bus.result), held_res);
        chk("ovf_hold", int'(bus.overflow), held_ovf);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", int'(bus.result), e.res);
          chk("overflow", int'(bus.overflow), e.ovf);
          chk("latency", cyc, e.cyc);
          held_res = e.res;
          held_ovf = e.ovf;
        end
      end
    end
  end

  initial begin
    int op, av, bv;
    bus.load = 1'b0;
    bus.opcode = 2'd0;
    bus.a = '0;
    bus.b = '0;
    idle(3);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    rst = 1'b0;
    idle(2);

    issue(2'd0, 200, 100, 1);
    chk("add_busy", int'(bus.busy), 1);
    wait_free();
    idle(1);
    issue(2'd0, 3, 4, 1); wait_free(); idle(1);
    issue(2'd1, 5, 9, 1); wait_free(); idle(1);
    issue(2'd1, 9, 5, 1); wait_free(); idle(1);
    issue(2'd2, 15, 17, 1); wait_free(); idle(1);
    issue(2'd2, 16, 16, 1); wait_free(); idle(1);
    issue(2'd3, 100, 7, 1); wait_free(); idle(1);
    issue(2'd3, 5, 0, 1); wait_free(); idle(1);

    issue(2'd2, 15, 17, 1);
    idle(1);
    issue(2'd0, 1, 1, 0);
    wait_free();
    chk("b2b_done", int'(bus.done), 1);
    issue(2'd1, 10, 3, 1);
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_nodone", int'(bus.done), 0);
    wait_free();
    idle(1);

    issue(2'd3, 100, 7, 0);
    idle(3);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_result", int'(bus.result), 0);
    chk("arst_ovf", int'(bus.overflow), 0);
    held_res = 0;
    held_ovf = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(12);
    issue(2'd0, 1, 2, 1); wait_free(); idle(1);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      av = $urandom_range(0, MASK);
      bv = ($urandom_range(0, 7) == 0) ? 0
         : $urandom_range(0, MASK);
      issue(op[1:0], av, bv, 1);
      wait_free();
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle ALU execution datapath.
- Serves as the responder to the ALU run-control state machine. The controller pulses load with an opcode and operands; this block executes the operation and reports completion (done) plus the overflow/error flag.
- The controller uses the overflow flag to take its run_error transition.
- Operations: ADD and SUB are single-cycle. MUL is iterative shift-add and DIV is iterative restoring; both take WIDTH cycles.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- load  input  1  start request; sampled only when not busy
- opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; captured with load
- a  input  WIDTH  operand A (unsigned); captured with load
- b  input  WIDTH  operand B (unsigned); captured with load
- busy  output  1  high while an operation executes
- done  output  1  one-cycle pulse: result and overflow are valid
- result  output  WIDTH  operation result; held until the next completion
- overflow  output  1  error flag for the last completed operation; held with result

Behaviour:
- Reset (asynchronous, any time):
  - state = IDLE; busy = 0, done = 0, result = 0, overflow = 0; internal registers cleared.
  - Reset mid-operation aborts it: no done pulse, and the captured operands are lost.
- States:
  - IDLE: accept load.
  - EXEC: iterate; busy = 1.
  - DONE: done = 1 for one cycle; load is accepted here as in IDLE.
- Transitions:
  - IDLE/DONE --load--> EXEC. On that edge, opcode, a, b are captured and the cycle counter is loaded.
  - DONE --!load--> IDLE.
  - EXEC --counter==0--> DONE. On that edge, result and overflow are registered.
- Latency, from the edge that samples load:
  - ADD/SUB: done on edge +1.
  - MUL/DIV: done on edge +WIDTH.
  - DIV with b==0: done on edge +1.
- load while busy: ignored. Operands and opcode are not re-captured, and the operation in flight is unaffected.
- busy is low in IDLE and DONE. done is never high in the same cycle as busy.
- ADD:
  - result = (a+b) mod 2^WIDTH.
  - overflow = carry out of the WIDTH-bit sum.
- SUB:
  - result = (a-b) mod 2^WIDTH.
  - overflow = borrow (a<b).
- MUL:
  - Forms a 2*WIDTH-bit product over WIDTH shift-add steps, one multiplier bit per cycle, LSB first.
  - result = low WIDTH bits of the product.
  - overflow = 1 iff the high WIDTH bits are nonzero.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - result = floor(a/b); the remainder is internal only.
  - overflow = 0 when b != 0.
  - When b==0: no iteration; result = all ones, overflow = 1.
- result and overflow change only on a DONE entry edge or on reset. They do not change during EXEC.
- Back-to-back: load asserted in the DONE cycle starts a new operation on the next edge, so done is followed directly by busy.

Test Plan (WIDTH=8):
- Reset then ADD a=200 b=100 -> busy for 1 cycle; done pulse on edge +1; result=44, overflow=1. Then ADD 3+4 -> result=7, overflow=0.
- SUB a=5 b=9 -> result=252, overflow=1. SUB a=9 b=5 -> result=4, overflow=0. Each completes in 1 cycle.
- MUL a=15 b=17 -> done on edge +8; result=255, overflow=0. MUL a=16 b=16 -> result=0, overflow=1. busy high for exactly 8 cycles.
- DIV a=100 b=7 -> done on edge +8; result=14, overflow=0. DIV a=5 b=0 -> done on edge +1; result=255, overflow=1.
- During MUL 15*17, pulse load with ADD 1+1 at cycle +3 -> ignored; result=255 at edge +8. Then assert load in the done cycle with SUB 10-3 -> result=7 one cycle later.
- Start DIV 100/7 and assert rst at cycle +4 -> busy=0, done=0, result=0, overflow=0 immediately (asynchronous); no done pulse follows. A subsequent ADD 1+2 -> result=3.
